// File: rtl/sbox_build_controller_pkg.sv
// Shared types and constants for the S-box build controller.
package sbox_ctrl_pkg;

  localparam int unsigned ROWS       = 16;
  localparam int unsigned ROW_BITS   = 128;
  localparam int unsigned SBOX_BYTES = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    SERVE   = 3'd4
  } ctrl_state_t;

  typedef logic [31:0] seed_word_t;
  typedef logic [7:0]  sbox_byte_t;

  // Byte j of a generator row, counted from the most significant byte.
  function automatic sbox_byte_t row_byte(input logic [ROW_BITS-1:0] row, input int unsigned j);
    return row[ROW_BITS-1-8*j -: 8];
  endfunction

endpackage

// File: rtl/sbox_build_controller_if.sv
// Seed handshake and two-port lookup channel of the S-box build controller.
interface sbox_build_controller_if;
  import sbox_ctrl_pkg::*;

  logic       seed_valid;
  logic       seed_ready;
  seed_word_t seed_x1;
  seed_word_t seed_x2;
  seed_word_t seed_x3;

  logic       req0_valid;
  logic       req1_valid;
  sbox_byte_t req0_addr;
  sbox_byte_t req1_addr;
  logic       req0_grant;
  logic       req1_grant;
  logic       rsp0_valid;
  logic       rsp1_valid;
  sbox_byte_t rsp0_data;
  sbox_byte_t rsp1_data;

  modport master (
    output seed_valid, seed_x1, seed_x2, seed_x3,
    output req0_valid, req1_valid, req0_addr, req1_addr,
    input  seed_ready, req0_grant, req1_grant,
    input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data
  );

  modport slave (
    input  seed_valid, seed_x1, seed_x2, seed_x3,
    input  req0_valid, req1_valid, req0_addr, req1_addr,
    output seed_ready, req0_grant, req1_grant,
    output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data
  );

endinterface

// File: rtl/sbox_build_controller_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered rr pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       rr
);

  // Grant the lone requester, or the one rr points at under contention.
  always_comb begin
    grant = '0;
    if (advance) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  // Pointer moves away from the winner only after a contended grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= 1'b0;
    end else if (advance && (valid == 2'b11)) begin
      rr <= ~rr;
    end
  end

endmodule

// File: rtl/sbox_build_controller.sv
// Sequences one chaotic S-box build, captures the result and serves byte lookups.
module sbox_build_controller
  import sbox_ctrl_pkg::*;
#(
  parameter int unsigned SEED_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  sbox_build_controller_if.slave   lk,
  output logic                     gen_reset,
  output logic                     gen_enable_bar,
  output seed_word_t               gen_x1_initial,
  output seed_word_t               gen_x2_initial,
  output seed_word_t               gen_x3_initial,
  input  logic                     gen_ready,
  input  logic [ROWS*ROW_BITS-1:0] gen_rows,
  output logic                     sbox_valid,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam logic [15:0] SEED_LAST    = 16'(SEED_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  ctrl_state_t state;
  ctrl_state_t next_state;
  logic [15:0] cnt;
  logic        seed_accept;
  logic        timeout_hit;
  logic        serve_en;
  logic [1:0]  grant;
  logic        arb_rr_unused;

  sbox_byte_t  sbox_table [SBOX_BYTES];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus seed-accept and timeout strobes.
  always_comb begin
    next_state  = state;
    seed_accept = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (lk.seed_valid) begin
          seed_accept = 1'b1;
          next_state  = SEED;
        end
      end
      SEED: begin
        if (cnt == SEED_LAST) next_state = RUN;
      end
      RUN: begin
        if (gen_ready) begin
          next_state = CAPTURE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
      end
      CAPTURE: next_state = SERVE;
      SERVE: begin
        if (lk.seed_valid) begin
          seed_accept = 1'b1;
          next_state  = SEED;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign lk.seed_ready  = (state == IDLE) || (state == SERVE);
  assign gen_reset      = (state != RUN);
  assign gen_enable_bar = (state != RUN);
  assign sbox_valid     = (state == SERVE);
  assign busy           = (state == SEED) || (state == RUN) || (state == CAPTURE);
  assign serve_en       = (state == SERVE) && !lk.seed_valid;

  // Per-state cycle counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (reset || (state != next_state)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Seed latch and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_x1_initial <= '0;
      gen_x2_initial <= '0;
      gen_x3_initial <= '0;
      timeout_err    <= 1'b0;
    end else if (seed_accept) begin
      gen_x1_initial <= lk.seed_x1;
      gen_x2_initial <= lk.seed_x2;
      gen_x3_initial <= lk.seed_x3;
      timeout_err    <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end

  // Capture generator rows into the table, most significant byte first.
  always_ff @(posedge clk) begin
    if (!reset && (state == CAPTURE)) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        for (int unsigned j = 0; j < ROWS; j++) begin
          sbox_table[8'(ROWS*i + j)] <= row_byte(gen_rows[ROW_BITS*i +: ROW_BITS], j);
        end
      end
    end
  end

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   ({lk.req1_valid, lk.req0_valid}),
    .advance (serve_en),
    .grant   (grant),
    .rr      (arb_rr_unused)
  );

  assign lk.req0_grant = grant[0];
  assign lk.req1_grant = grant[1];

  // Lookup responses, one cycle after grant; data holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk.rsp0_valid <= 1'b0;
      lk.rsp1_valid <= 1'b0;
      lk.rsp0_data  <= '0;
      lk.rsp1_data  <= '0;
    end else begin
      lk.rsp0_valid <= grant[0];
      lk.rsp1_valid <= grant[1];
      if (grant[0]) lk.rsp0_data <= sbox_table[lk.req0_addr];
      if (grant[1]) lk.rsp1_data <= sbox_table[lk.req1_addr];
    end
  end

endmodule

// File: tb/tb_sbox_build_controller.sv
// Self-checking bench for sbox_build_controller with a stub S-box generator.
module tb_sbox_build_controller;
  import sbox_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sbox_build_controller_if lk ();
  sbox_build_controller_if lk2 ();

  logic                     gen_reset, gen_enable_bar, sbox_valid, busy, timeout_err;
  logic [31:0]              gx1, gx2, gx3;
  logic                     gen_ready = 1'b0;
  logic [ROWS*ROW_BITS-1:0] gen_rows  = '0;

  logic                     gen_reset2, gen_enable_bar2, sbox_valid2, busy2, timeout_err2;
  logic [31:0]              hx1, hx2, hx3;
  logic                     gen_ready2;
  logic [ROWS*ROW_BITS-1:0] gen_rows2;
  assign gen_ready2 = 1'b0;
  assign gen_rows2  = '0;

  sbox_build_controller #(.SEED_CYCLES(2), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .reset(reset), .lk(lk),
    .gen_reset(gen_reset), .gen_enable_bar(gen_enable_bar),
    .gen_x1_initial(gx1), .gen_x2_initial(gx2), .gen_x3_initial(gx3),
    .gen_ready(gen_ready), .gen_rows(gen_rows),
    .sbox_valid(sbox_valid), .busy(busy), .timeout_err(timeout_err)
  );

  sbox_build_controller #(.SEED_CYCLES(2), .TIMEOUT_CYCLES(16)) dut2 (
    .clk(clk), .reset(reset), .lk(lk2),
    .gen_reset(gen_reset2), .gen_enable_bar(gen_enable_bar2),
    .gen_x1_initial(hx1), .gen_x2_initial(hx2), .gen_x3_initial(hx3),
    .gen_ready(gen_ready2), .gen_rows(gen_rows2),
    .sbox_valid(sbox_valid2), .busy(busy2), .timeout_err(timeout_err2)
  );

  // Stub generator: ready 20 cycles after gen_reset falls.
  int unsigned stub_cnt = 0;
  always @(posedge clk) begin
    if (gen_reset !== 1'b0) begin
      stub_cnt  <= 0;
      gen_ready <= 1'b0;
    end else if (stub_cnt == 19) begin
      gen_ready <= 1'b1;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  int         checks   = 0;
  int         failures = 0;
  bit         rr_m     = 1'b0;
  logic [7:0] tbl [SBOX_BYTES];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_table(input bit rnd);
    for (int k = 0; k < SBOX_BYTES; k++) begin
      tbl[k] = rnd ? 8'($urandom) : (8'(k) ^ 8'hA5);
      gen_rows[ROW_BITS*(k/ROWS) + ROW_BITS - 1 - 8*(k%ROWS) -: 8] = tbl[k];
    end
  endtask

  task automatic idle_inputs();
    lk.seed_valid = 0; lk.seed_x1 = '0; lk.seed_x2 = '0; lk.seed_x3 = '0;
    lk.req0_valid = 0; lk.req1_valid = 0; lk.req0_addr = '0; lk.req1_addr = '0;
    lk2.seed_valid = 0; lk2.seed_x1 = '0; lk2.seed_x2 = '0; lk2.seed_x3 = '0;
    lk2.req0_valid = 0; lk2.req1_valid = 0; lk2.req0_addr = '0; lk2.req1_addr = '0;
  endtask

  task automatic send_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    lk.seed_valid = 1; lk.seed_x1 = a; lk.seed_x2 = b; lk.seed_x3 = c;
    @(negedge clk);
    lk.seed_valid = 0;
  endtask

  task automatic wait_serve(input int budget);
    int n = 0;
    while (sbox_valid !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    checks++; if (sbox_valid !== 1'b1) begin failures++; $display("FAIL wait_serve sbox_valid=%0b exp=1 after %0d cycles", sbox_valid, n); end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    rr_m  = 0;
    checks++; if (lk.seed_ready !== 1'b1) begin failures++; $display("FAIL rst_seed_ready got=%0b exp=1", lk.seed_ready); end
    checks++; if (gen_reset !== 1'b1 || gen_enable_bar !== 1'b1) begin failures++; $display("FAIL rst_gen got=%0b%0b exp=11", gen_reset, gen_enable_bar); end
    checks++; if ({gx1, gx2, gx3} !== 96'd0) begin failures++; $display("FAIL rst_seeds got=%h exp=0", {gx1, gx2, gx3}); end
    checks++; if ({sbox_valid, busy, timeout_err} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", {sbox_valid, busy, timeout_err}); end
    checks++; if ({lk.rsp0_valid, lk.rsp1_valid, lk.rsp0_data, lk.rsp1_data} !== 18'd0) begin failures++; $display("FAIL rst_rsp got=%h exp=0", {lk.rsp0_valid, lk.rsp1_valid, lk.rsp0_data, lk.rsp1_data}); end
    checks++; if (busy2 !== 1'b0 || timeout_err2 !== 1'b0) begin failures++; $display("FAIL rst_dut2 got=%0b%0b exp=00", busy2, timeout_err2); end
  endtask

  task automatic test_timeout();
    int n_run = 0;
    int n     = 0;
    @(negedge clk);
    lk2.seed_valid = 1; lk2.seed_x1 = 32'h12345678;
    @(negedge clk);
    lk2.seed_valid = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (gen_reset2 === 1'b0) n_run++;
      else if (n_run > 0) break;
    end
    checks++; if (n_run != 16) begin failures++; $display("FAIL to_run_cycles got=%0d exp=16", n_run); end
    checks++; if (timeout_err2 !== 1'b1) begin failures++; $display("FAIL to_err got=%0b exp=1", timeout_err2); end
    checks++; if (sbox_valid2 !== 1'b0 || busy2 !== 1'b0 || lk2.seed_ready !== 1'b1) begin failures++; $display("FAIL to_idle got=%0b%0b%0b exp=001", sbox_valid2, busy2, lk2.seed_ready); end
    @(negedge clk);
    lk2.seed_valid = 1;
    @(negedge clk);
    lk2.seed_valid = 0;
    checks++; if (timeout_err2 !== 1'b0 || busy2 !== 1'b1) begin failures++; $display("FAIL to_clear got=%0b%0b exp=01", timeout_err2, busy2); end
  endtask

  task automatic test_seed();
    int n = 0;
    set_table(0);
    send_seed(32'h3DCCCD53, 32'h3C23D70A, 32'h00000000);
    checks++; if (lk.seed_ready !== 1'b0 || gen_reset !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL seed_c1 got=%0b%0b%0b exp=011", lk.seed_ready, gen_reset, busy); end
    checks++; if ({gx1, gx2, gx3} !== {32'h3DCCCD53, 32'h3C23D70A, 32'h0}) begin failures++; $display("FAIL seed_latch got=%h exp=3dcccd533c23d70a00000000", {gx1, gx2, gx3}); end
    @(negedge clk);
    checks++; if (lk.seed_ready !== 1'b0 || gen_reset !== 1'b1) begin failures++; $display("FAIL seed_c2 got=%0b%0b exp=01", lk.seed_ready, gen_reset); end
    @(negedge clk);
    checks++; if (gen_reset !== 1'b0 || gen_enable_bar !== 1'b0) begin failures++; $display("FAIL seed_run got=%0b%0b exp=00", gen_reset, gen_enable_bar); end
    while (gen_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (sbox_valid !== 1'b0 || gen_ready !== 1'b1) begin failures++; $display("FAIL seed_ready_cyc got=%0b%0b exp=01", sbox_valid, gen_ready); end
    @(negedge clk);
    checks++; if (sbox_valid !== 1'b0 || busy !== 1'b1 || gen_reset !== 1'b1) begin failures++; $display("FAIL seed_capture got=%0b%0b%0b exp=011", sbox_valid, busy, gen_reset); end
    @(negedge clk);
    checks++; if (sbox_valid !== 1'b1 || busy !== 1'b0 || lk.seed_ready !== 1'b1) begin failures++; $display("FAIL seed_serve got=%0b%0b%0b exp=101", sbox_valid, busy, lk.seed_ready); end
  endtask

  task automatic test_single();
    logic [7:0] addrs [3] = '{8'h00, 8'hFF, 8'h7E};
    int         who   [3] = '{0, 0, 1};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (who[t] == 0) begin lk.req0_valid = 1; lk.req0_addr = addrs[t]; end
      else             begin lk.req1_valid = 1; lk.req1_addr = addrs[t]; end
      #1;
      checks++; if ({lk.req1_grant, lk.req0_grant} !== (who[t] == 0 ? 2'b01 : 2'b10)) begin failures++; $display("FAIL single_grant%0d got=%b", t, {lk.req1_grant, lk.req0_grant}); end
      @(negedge clk);
      lk.req0_valid = 0; lk.req1_valid = 0;
      if (who[t] == 0) begin
        checks++; if (lk.rsp0_valid !== 1'b1 || lk.rsp0_data !== (addrs[t] ^ 8'hA5)) begin failures++; $display("FAIL single_rsp0_%0d got=%0b/%h exp=1/%h", t, lk.rsp0_valid, lk.rsp0_data, addrs[t] ^ 8'hA5); end
      end else begin
        checks++; if (lk.rsp1_valid !== 1'b1 || lk.rsp1_data !== (addrs[t] ^ 8'hA5)) begin failures++; $display("FAIL single_rsp1_%0d got=%0b/%h exp=1/%h", t, lk.rsp1_valid, lk.rsp1_data, addrs[t] ^ 8'hA5); end
      end
      @(negedge clk);
      checks++; if (lk.rsp0_valid !== 1'b0 || lk.rsp1_valid !== 1'b0) begin failures++; $display("FAIL single_idle%0d got=%0b%0b exp=00", t, lk.rsp0_valid, lk.rsp1_valid); end
    end
    checks++; if (lk.rsp0_data !== 8'h5A) begin failures++; $display("FAIL single_hold got=%h exp=5a", lk.rsp0_data); end
  endtask

  task automatic test_both();
    logic [1:0] exp_g;
    logic [1:0] prev_g = 2'b00;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (prev_g == 2'b01) begin
        checks++; if ({lk.rsp1_valid, lk.rsp0_valid} !== 2'b01 || lk.rsp0_data !== 8'hB5) begin failures++; $display("FAIL both_rsp%0d got=%b/%h exp=01/b5", c, {lk.rsp1_valid, lk.rsp0_valid}, lk.rsp0_data); end
      end else if (prev_g == 2'b10) begin
        checks++; if ({lk.rsp1_valid, lk.rsp0_valid} !== 2'b10 || lk.rsp1_data !== 8'h85) begin failures++; $display("FAIL both_rsp%0d got=%b/%h exp=10/85", c, {lk.rsp1_valid, lk.rsp0_valid}, lk.rsp1_data); end
      end
      if (c == 4) break;
      lk.req0_valid = 1; lk.req0_addr = 8'h10;
      lk.req1_valid = 1; lk.req1_addr = 8'h20;
      #1;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if ({lk.req1_grant, lk.req0_grant} !== exp_g) begin failures++; $display("FAIL both_grant%0d got=%b exp=%b", c, {lk.req1_grant, lk.req0_grant}, exp_g); end
      rr_m   = ~rr_m;
      prev_g = exp_g;
    end
    lk.req0_valid = 0; lk.req1_valid = 0;
  endtask

  task automatic test_random();
    bit         pend   [2] = '{0, 0};
    logic [7:0] addr   [2] = '{8'h00, 8'h00};
    bit         exp_rv [2] = '{0, 0};
    logic [7:0] exp_rd [2] = '{8'h00, 8'h00};
    bit         have   [2] = '{0, 0};
    logic [7:0] rd     [2];
    logic [1:0] rv, exp_g, got_g;
    set_table(1);
    send_seed($urandom, $urandom, $urandom);
    wait_serve(200);
    for (int cyc = 0; cyc <= 300; cyc++) begin
      @(negedge clk);
      rv = {lk.rsp1_valid, lk.rsp0_valid};
      rd[0] = lk.rsp0_data; rd[1] = lk.rsp1_data;
      for (int k = 0; k < 2; k++) begin
        checks++; if (rv[k] !== exp_rv[k]) begin failures++; $display("FAIL rand_rv%0d cyc=%0d got=%0b exp=%0b", k, cyc, rv[k], exp_rv[k]); end
        if (have[k]) begin
          checks++; if (rd[k] !== exp_rd[k]) begin failures++; $display("FAIL rand_rd%0d cyc=%0d got=%h exp=%h", k, cyc, rd[k], exp_rd[k]); end
        end
      end
      if (cyc == 300) break;
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(1, 0) == 1) begin pend[k] = 1; addr[k] = 8'($urandom); end
      end
      lk.req0_valid = pend[0]; lk.req0_addr = addr[0];
      lk.req1_valid = pend[1]; lk.req1_addr = addr[1];
      #1;
      if (pend[0] && pend[1]) begin
        exp_g = rr_m ? 2'b10 : 2'b01;
        rr_m  = ~rr_m;
      end else begin
        exp_g = {pend[1], pend[0]};
      end
      got_g = {lk.req1_grant, lk.req0_grant};
      checks++; if (got_g !== exp_g) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, got_g, exp_g); end
      for (int k = 0; k < 2; k++) begin
        exp_rv[k] = exp_g[k];
        if (exp_g[k]) begin exp_rd[k] = tbl[addr[k]]; have[k] = 1; pend[k] = 0; end
      end
    end
    lk.req0_valid = 0; lk.req1_valid = 0;
  endtask

  task automatic test_seed_in_serve();
    @(negedge clk);
    lk.req1_valid = 1; lk.req1_addr = 8'h33;
    #1;
    checks++; if ({lk.req1_grant, lk.req0_grant} !== 2'b10) begin failures++; $display("FAIL sis_grant got=%b exp=10", {lk.req1_grant, lk.req0_grant}); end
    @(negedge clk);
    lk.req1_valid = 0;
    lk.req0_valid = 1; lk.req0_addr = 8'h44;
    lk.seed_valid = 1; lk.seed_x1 = $urandom; lk.seed_x2 = $urandom; lk.seed_x3 = $urandom;
    #1;
    checks++; if ({lk.req1_grant, lk.req0_grant} !== 2'b00) begin failures++; $display("FAIL sis_nogrant got=%b exp=00", {lk.req1_grant, lk.req0_grant}); end
    checks++; if (lk.rsp1_valid !== 1'b1 || lk.rsp1_data !== tbl[8'h33]) begin failures++; $display("FAIL sis_rsp1 got=%0b/%h exp=1/%h", lk.rsp1_valid, lk.rsp1_data, tbl[8'h33]); end
    @(negedge clk);
    lk.seed_valid = 0; lk.req0_valid = 0;
    checks++; if (sbox_valid !== 1'b0 || busy !== 1'b1 || lk.seed_ready !== 1'b0) begin failures++; $display("FAIL sis_state got=%0b%0b%0b exp=010", sbox_valid, busy, lk.seed_ready); end
    checks++; if (lk.rsp0_valid !== 1'b0 || lk.rsp1_valid !== 1'b0) begin failures++; $display("FAIL sis_norsp got=%0b%0b exp=00", lk.rsp0_valid, lk.rsp1_valid); end
    wait_serve(200);
  endtask

  task automatic test_reset_run();
    send_seed(32'hCAFEF00D, 32'h1, 32'h2);
    repeat (2) @(negedge clk);
    checks++; if (gen_reset !== 1'b0) begin failures++; $display("FAIL rr_in_run got=%0b exp=0", gen_reset); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    rr_m  = 0;
    checks++; if (gen_reset !== 1'b1 || gen_enable_bar !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rr_idle got=%0b%0b%0b exp=110", gen_reset, gen_enable_bar, busy); end
    checks++; if (lk.rsp0_valid !== 1'b0 || lk.rsp1_valid !== 1'b0 || sbox_valid !== 1'b0) begin failures++; $display("FAIL rr_outs got=%0b%0b%0b exp=000", lk.rsp0_valid, lk.rsp1_valid, sbox_valid); end
    checks++; if (gx1 !== 32'h0 || lk.seed_ready !== 1'b1) begin failures++; $display("FAIL rr_seed got=%h/%0b exp=0/1", gx1, lk.seed_ready); end
    send_seed(32'h1, 32'h2, 32'h3);
    wait_serve(200);
    @(negedge clk);
    lk.req0_valid = 1; lk.req0_addr = 8'h05;
    reset = 1;
    #1;
    checks++; if (lk.req0_grant !== 1'b1) begin failures++; $display("FAIL rs_grant got=%0b exp=1", lk.req0_grant); end
    @(negedge clk);
    reset = 0; lk.req0_valid = 0;
    rr_m  = 0;
    checks++; if (lk.rsp0_valid !== 1'b0 || lk.rsp0_data !== 8'h00 || sbox_valid !== 1'b0) begin failures++; $display("FAIL rs_discard got=%0b/%h/%0b exp=0/00/0", lk.rsp0_valid, lk.rsp0_data, sbox_valid); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_seed();
    test_single();
    test_both();
    test_random();
    test_seed_in_serve();
    test_reset_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbox_build_controller.md
Name: sbox_build_controller

Overview:
Sequences one S-box build: accepts a 3-word chaos seed, drives chaos_generator and substitution_box_generator, and waits for the generator's ready with a timeout. It then captures the 16x128-bit result into a 256-byte table and serves byte lookups to two requesters through a round-robin arbiter, one lookup per cycle. It sits between the key-schedule/cipher datapath and the chaotic S-box generation pair.

Parameters:
SEED_CYCLES, 2, cycles gen_reset is held high after seed accept before the generator runs (>=1)
TIMEOUT_CYCLES, 4096, maximum RUN cycles to wait for gen_ready before aborting (<=65535)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-high
seed_valid  in  1  seed offer
seed_ready  out  1  controller can accept a seed
seed_x1, seed_x2, seed_x3  in  32 each  initial chaos state (IEEE-754 single)
gen_reset  out  1  drives reset of chaos_generator and substitution_box_generator
gen_enable_bar  out  1  active-low enable to substitution_box_generator
gen_x1_initial, gen_x2_initial, gen_x3_initial  out  32 each  latched seeds to chaos_generator
gen_ready  in  1  substitution_box_generator ready
gen_rows  in  2048  row i = gen_rows[128*i +: 128], i = 0..15
req0_valid, req1_valid  in  1 each  lookup request
req0_addr, req1_addr  in  8 each  S-box index
req0_grant, req1_grant  out  1 each  combinational grant
rsp0_valid, rsp1_valid  out  1 each  response strobe, 1 cycle after grant
rsp0_data, rsp1_data  out  8 each  S-box byte
sbox_valid  out  1  table holds a completed build
busy  out  1  build in progress (SEED/RUN/CAPTURE)
timeout_err  out  1  sticky; last build timed out

Behaviour:
- The clock port is clk and the reset port is reset: one clock, reset synchronous and active-high.
- Reset values: state=IDLE; gen_reset=1; gen_enable_bar=1; gen_x*_initial=0; sbox_valid=0; busy=0; timeout_err=0; rsp*_valid=0; rsp*_data=0; rr pointer=0. Table contents are not reset.
- Reset asserted mid-build or mid-serve returns to IDLE the next edge, drops sbox_valid, and discards the in-flight response.
- States: IDLE, SEED, RUN, CAPTURE, SERVE.
- IDLE: seed_ready=1, gen_reset=1, gen_enable_bar=1. A seed_valid&&seed_ready edge latches seeds into gen_x*_initial, clears timeout_err, and moves to SEED.
- SEED: gen_reset=1 and gen_enable_bar=1 for exactly SEED_CYCLES cycles, then RUN.
- RUN: gen_reset=0 and gen_enable_bar=0. A 16-bit counter starts at 0 on entry.
  - gen_ready=1 goes to CAPTURE.
  - If the counter reaches TIMEOUT_CYCLES-1 without gen_ready, set timeout_err=1 and go to IDLE.
  - gen_ready and the timeout in the same cycle: gen_ready wins.
- CAPTURE (1 cycle): table[16*i+j] <= gen_rows[128*i + 127 - 8*j -: 8], i.e. MSB byte first within each row. gen_reset=1 and gen_enable_bar=1 from here on. Next state is SERVE.
- SERVE: sbox_valid=1 and seed_ready=1. busy=1 only in SEED/RUN/CAPTURE.
- Arbitration (SERVE only, and not in the cycle a seed is accepted):
  - At most one grant per cycle.
  - With a single requester valid, that requester is granted.
  - With both valid, the requester indicated by rr is granted, then rr flips to the other.
  - Grant is combinational from valid. A requester holds valid and addr until granted.
- Response: rsp_k_valid=1 exactly one cycle after grant_k, with rsp_k_data = table[addr captured at grant]. rsp*_data holds its value when rsp*_valid=0.
- Seed accepted in SERVE:
  - sbox_valid drops on the next edge, and there are no grants in the accept cycle.
  - A response granted in the prior cycle is still delivered, because the table is unchanged until CAPTURE.
  - State goes to SEED.
- Outside SERVE, all grants are 0 and requests stall.

Decomposition:
- Package sbox_ctrl_pkg holds:
  - state encoding localparams: IDLE=0, SEED=1, RUN=2, CAPTURE=3, SERVE=4
  - ROWS=16, ROW_BITS=128, SBOX_BYTES=256
- Sub-module rr_arbiter2 takes valid[1:0] and an advance input, and outputs grant[1:0] plus the registered rr pointer.
- The table and FSM stay in the top module.

Test Plan:
- Bench setup: a stub generator asserts gen_ready 20 cycles after gen_reset falls, with table byte k = k ^ 8'hA5.
- Reset then seed (3DCCCD53, 3C23D70A, 00000000) -> seed_ready=0 for 2 SEED cycles; gen_reset falls 2 cycles after accept; gen_x1_initial=3DCCCD53; sbox_valid=1 two cycles after gen_ready.
- SERVE, req0 addr 0x00 alone -> grant0 same cycle; rsp0_valid next cycle with data 0xA5. Then addr 0xFF -> 0x5A.
- Both requesters valid for 4 cycles, addr0=0x10, addr1=0x20 -> grants alternate 0,1,0,1; rsp data alternate 0xB5, 0x85.
- Stub never raises gen_ready, TIMEOUT_CYCLES=16 -> back to IDLE 16 RUN cycles after entry; timeout_err=1; sbox_valid=0. The next seed accept clears timeout_err.
- New seed accepted in SERVE while req1 was granted the previous cycle -> rsp1_valid still 1; no grants in the accept cycle; sbox_valid=0 the next cycle; busy=1.
- reset pulsed during RUN -> IDLE next cycle; gen_reset=1; gen_enable_bar=1; no rsp*_valid.
